pipe_hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage core. It watches the decode, execute and memory stages and drives the hold and bubble controls of the F→D and D→EX pipeline registers. It handles three cases: load-use stalls, taken-branch redirect/flush windows, and data-memory wait states. It also keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/sat_counter.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg: shared encodings for the pipeline hazard controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter: W-bit event counter that sticks at all-ones.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl: load-use, branch-flush and memory-wait sequencing. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNTW         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      D_rs1,
  input  logic [4:0]      D_rs2,
  input  logic            D_use_rs1,
  input  logic            D_use_rs2,
  input  logic            EX_ld,
  input  logic            EX_we,
  input  logic [4:0]      EX_rd,
  input  logic            EX_brn_taken,
  input  logic            MEM_req,
  input  logic            MEM_ready,
  output logic            F_stall,
  output logic            D_stall,
  output logic            EX_stall,
  output logic            D_flush,
  output logic            F_flush,
  output logic            pc_redirect,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam logic [2:0] FCNT_LOAD   = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
  // XLEN only qualifies the output enable so the parameter stays referenced.
  localparam bit         XLEN_OK     = (XLEN > 0);

  state_e     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;

  logic w_memwait, w_load_use, w_active;
  logic w_f_stall, w_d_stall, w_ex_stall, w_f_flush, w_d_flush, w_redirect;

  assign w_memwait  = MEM_req & ~MEM_ready;
  assign w_load_use = EX_ld & EX_we & (EX_rd != REG_ZERO) &
                      ((D_use_rs1 & (D_rs1 == EX_rd)) |
                       (D_use_rs2 & (D_rs2 == EX_rd)));

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    w_f_stall  = 1'b0;
    w_d_stall  = 1'b0;
    w_ex_stall = 1'b0;
    w_f_flush  = 1'b0;
    w_d_flush  = 1'b0;
    w_redirect = 1'b0;
    if (w_memwait) begin
      // Everything freezes; a pending branch or load-use is retried on release.
      w_f_stall  = 1'b1;
      w_d_stall  = 1'b1;
      w_ex_stall = 1'b1;
      if (state_q == RUN) begin
        state_d = MEM_WAIT;
      end
    end else if (EX_brn_taken) begin
      w_redirect = 1'b1;
      w_f_flush  = 1'b1;
      w_d_flush  = 1'b1;
      fcnt_d     = FCNT_LOAD;
      state_d    = MULTI_FLUSH ? REDIRECT : RUN;
    end else if (state_q == REDIRECT) begin
      if (fcnt_q != 3'd0) begin
        w_f_flush = 1'b1;
        fcnt_d    = fcnt_q - 3'd1;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
      if (w_load_use) begin
        w_f_stall = 1'b1;
        w_d_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign w_active    = rst_n & XLEN_OK;
  assign F_stall     = w_active & w_f_stall;
  assign D_stall     = w_active & w_d_stall;
  assign EX_stall    = w_active & w_ex_stall;
  assign F_flush     = w_active & w_f_flush;
  assign D_flush     = w_active & w_d_flush;
  assign pc_redirect = w_active & w_redirect;

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (F_stall),
    .clr   (1'b0),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_redirect),
    .clr   (1'b0),
    .cnt   (flush_cnt)
  );

endmodule

`default_nettype wire
